// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM state encoding and port indices.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick between CPU and DMA, with a bounded DMA burst-lock override.
module arb_rr2
  import mem_arb_pkg::*;
#(
  parameter int unsigned LOCK_MAX = 32'd4
) (
  input  logic clk,
  input  logic rst,
  input  logic cpu_req,
  input  logic dma_req,
  input  logic dma_lock,
  input  logic accept,
  output logic winner
);

  localparam int unsigned CW = $clog2(LOCK_MAX + 32'd1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);

  logic          last_q, last_d;
  logic          lock_q, lock_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          locked_s;

  // Winner selection; once the lock budget is spent, round-robin hands the turn to the CPU.
  always_comb begin
    locked_s = (last_q == PORT_DMA) && lock_q && (cnt_q != CNT_MAX);
    if (cpu_req && dma_req) begin
      if (locked_s) begin
        winner = PORT_DMA;
      end else begin
        winner = ~last_q;
      end
    end else if (dma_req) begin
      winner = PORT_DMA;
    end else begin
      winner = PORT_CPU;
    end
  end

  // Pointer, lock flag and lock counter update on each accepted grant.
  always_comb begin
    last_d = last_q;
    lock_d = lock_q;
    cnt_d  = cnt_q;
    if (accept) begin
      last_d = winner;
      lock_d = (winner == PORT_DMA) && dma_lock;
      if ((winner == PORT_CPU) || !dma_lock) begin
        cnt_d = '0;
      end else if (cpu_req && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      last_d = last_q;
    end
  end

  // State registers; the pointer starts at DMA so the CPU wins the first contest.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= PORT_DMA;
      lock_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      last_q <= last_d;
      lock_q <= lock_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Two-port memory arbiter: CPU and DMA share one memory through a req/ack handshake.
// Grant choice comes from arb_rr2; latency counting and data capture live here.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW       = 32'd32,
  parameter int unsigned DW       = 32'd32,
  parameter int unsigned MEM_LAT  = 32'd1,
  parameter int unsigned LOCK_MAX = 32'd4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  input  logic          dma_lock,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner
);

  localparam int unsigned CW = (MEM_LAT > 32'd2) ? $clog2(MEM_LAT) : 32'd1;
  localparam logic [CW-1:0] WAIT_LAST = CW'((MEM_LAT >= 32'd2) ? (MEM_LAT - 32'd2) : 32'd0);

  state_e        state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          owner_q, owner_d;
  logic          cpu_ack_q, cpu_ack_d, dma_ack_q, dma_ack_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
  logic          grant_s, winner_s, resp_s;

  arb_rr2 #(.LOCK_MAX(LOCK_MAX)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .cpu_req  (cpu_req),
    .dma_req  (dma_req),
    .dma_lock (dma_lock),
    .accept   (grant_s),
    .winner   (winner_s)
  );

  // Next-state and output computation for the IDLE/ISSUE/WAIT/RESP sequence.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    owner_d     = owner_q;
    grant_s     = 1'b0;
    resp_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req || dma_req) begin
          grant_s  = 1'b1;
          state_d  = ISSUE;
          mem_en_d = 1'b1;
          owner_d  = winner_s;
          if (winner_s == PORT_DMA) begin
            mem_we_d    = dma_we;
            mem_addr_d  = dma_addr;
            mem_wdata_d = dma_wdata;
          end else begin
            mem_we_d    = cpu_we;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (MEM_LAT == 32'd1) begin
          state_d = RESP;
          resp_s  = 1'b1;
        end else begin
          state_d = WAIT;
          wcnt_d  = '0;
        end
      end
      WAIT: begin
        if (wcnt_q == WAIT_LAST) begin
          state_d = RESP;
          resp_s  = 1'b1;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cpu_ack_d   = resp_s && (owner_q == PORT_CPU);
    dma_ack_d   = resp_s && (owner_q == PORT_DMA);
    cpu_rdata_d = cpu_ack_d ? mem_rdata : cpu_rdata_q;
    dma_rdata_d = dma_ack_d ? mem_rdata : dma_rdata_q;
  end

  // Registers; reset drops any in-flight transaction without an ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      owner_q     <= PORT_CPU;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      owner_q     <= owner_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign owner     = owner_q;
  assign cpu_ack   = cpu_ack_q;
  assign dma_ack   = dma_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;

endmodule

// File: doc/mem_arb.md
# mem_arb

Two-port arbiter for the single unified memory of the multicycle CPU. It shares that memory between the CPU port, which carries instruction fetch and load/store, and a DMA/loader port. Each port gets one-transaction-at-a-time access through a req/ack handshake. The CPU control FSM holds its current state until `cpu_ack`, so the arbiter's wait cycles appear to the CPU as stall cycles.

## Interface
- `AW`, 32: address width.
- `DW`, 32: data width.
- `MEM_LAT`, 1: cycles from `mem_en` to valid `mem_rdata`. Must be ≥1.
- `LOCK_MAX`, 4: maximum consecutive locked DMA grants while the CPU is waiting. Must be ≥1.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `cpu_req`  in  1  CPU transaction request. Held until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  AW  byte address.
- `cpu_wdata`  in  DW  write data.
- `cpu_rdata`  out  DW  read data. Valid while `cpu_ack`=1.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_rdata`, `dma_ack`: same meanings as the CPU signals.
- `dma_lock`  in  1  requests that DMA keep ownership for its next request (burst).
- `mem_en`  out  1  memory access strobe. One cycle per transaction.
- `mem_we`  out  1  memory write enable. Qualified by `mem_en`.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data.
- `owner`  out  1  0 = CPU, 1 = DMA. Current or last grantee.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE → ISSUE when any request is present. Otherwise stay in IDLE.
- IDLE → ISSUE latches the grantee's `we`, `addr` and `wdata` into the `mem_*` registers and sets `owner`.
- ISSUE: `mem_en`=1 for exactly one cycle.
  - ISSUE → RESP if `MEM_LAT`=1.
  - ISSUE → WAIT otherwise.
- WAIT: counts `MEM_LAT`-1 cycles, then goes to RESP.
- RESP:
  - The grantee's ack is 1. The other port's ack is 0.
  - Its rdata register is loaded from `mem_rdata` on the WAIT/ISSUE→RESP edge. The loaded value is undefined for writes.
  - RESP → IDLE.
- Arbitration is decided in IDLE only.
  - If one port requests, that port wins.
  - If both request, default is round-robin: the port not granted last wins.
  - Lock override: if the last grant went to DMA, `dma_lock` was 1 at that grant, and `dma_req`=1, DMA wins regardless of round-robin.
  - Lock limit: a locked grant made while `cpu_req`=1 increments `lock_cnt`. When `lock_cnt` = `LOCK_MAX`, the CPU wins the next contested decision.
  - `lock_cnt` clears on any CPU grant or any grant with `dma_lock`=0.
- The round-robin pointer resets to "last = DMA", so the CPU wins the first contested decision after reset.
- A request still high in the IDLE after RESP counts as a new request.
- Requesters keep `addr`, `we` and `wdata` stable only until the IDLE→ISSUE edge. Afterwards the registered copies are used.
- Reset (`rst`=0, at any time, including mid-transaction):
  - FSM → IDLE. Any pending transaction is dropped with no ack.
  - A write already strobed is not undone.
  - `owner`=0, `lock_cnt`=0, pointer = DMA.

## Timing
- Reset values of all outputs: `cpu_ack`=`dma_ack`=`mem_en`=`mem_we`=0. `mem_addr`, `mem_wdata`, `cpu_rdata`, `dma_rdata` = 0. `owner`=0.
- Request sampled in IDLE at cycle 0 → `mem_en`=1 at cycle 1 → ack at cycle 1+`MEM_LAT`.
- Request-to-ack latency = `MEM_LAT`+1 cycles.
- Transaction occupancy = `MEM_LAT`+2 cycles, including the return to IDLE.
- Throughput: one transaction per `MEM_LAT`+2 cycles.
- With `MEM_LAT`=1, back-to-back CPU fetches complete every 3 cycles.
- `mem_*` outputs are registered and hold their value after ISSUE until the next grant.
- `cpu_ack` and `dma_ack` are never 1 in the same cycle.

## Structure
- Shared package `mem_arb_pkg` contains:
  - the state enum (IDLE/ISSUE/WAIT/RESP);
  - port index constants `PORT_CPU`=0 and `PORT_DMA`=1.
- One sub-module, `arb_rr2`: the two-way round-robin pick with the lock override.
  - Holds the last-grant pointer and `lock_cnt`.
  - Inputs: the two reqs, `dma_lock`, and a grant-accept strobe.
  - Outputs: the winner.
- The latency counter and data registers stay in `mem_arb`.

## Test plan
- Single CPU read, `MEM_LAT`=1, `cpu_addr`=0x40, `mem_rdata`=0x1234_5678 → `mem_en` at cycle 1, `cpu_ack`=1 with `cpu_rdata`=0x1234_5678 at cycle 2, `owner`=0.
- `cpu_req` and `dma_req` both held high, `dma_lock`=0 → grants alternate CPU, DMA, CPU, DMA; one ack every 3 cycles.
- DMA burst with `dma_lock`=1 and `cpu_req` held, `LOCK_MAX`=4 → exactly 4 consecutive DMA acks, then a CPU grant; `lock_cnt` returns to 0.
- `MEM_LAT`=3, DMA write `addr`=0x100, `wdata`=0xDEAD_BEEF → one `mem_en` with `mem_we`=1 and matching addr/data; `dma_ack` at cycle 4; no `cpu_ack`.
- `rst` pulled low during WAIT of a CPU read → all outputs reset immediately, no ack; after release a pending `dma_req` alone is granted normally.
- `cpu_addr` changed the cycle after the grant → `mem_addr` keeps the latched original value through RESP.
